// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Registered MIPS ALU with valid/ready handshakes on input and
//            output. Single-cycle ops (ADD/SUB/AND/OR/NOR/SLT/SLTU/SLL/SRL/
//            SRA) return one cycle after accept. An optional iterative
//            multiply/divide sequencer (MULLO/MULHU/DIVU/REMU) is built when
//            the macro ALU_PIPE_MULDIV_EN is defined. Without it, ops A-D
//            act as ADD.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready, op, a, b, shamt : operation input
//            out_valid/out_ready, result, zero, overflow : result output
//            busy : multi-cycle sequencer running
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam logic [3:0] c_op_add   = 4'h0;
    localparam logic [3:0] c_op_sub   = 4'h1;
    localparam logic [3:0] c_op_and   = 4'h2;
    localparam logic [3:0] c_op_or    = 4'h3;
    localparam logic [3:0] c_op_nor   = 4'h4;
    localparam logic [3:0] c_op_slt   = 4'h5;
    localparam logic [3:0] c_op_sltu  = 4'h6;
    localparam logic [3:0] c_op_sll   = 4'h7;
    localparam logic [3:0] c_op_srl   = 4'h8;
    localparam logic [3:0] c_op_sra   = 4'h9;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic             w_fire_in;
    logic             w_out_free;
    logic             w_single;     // accepted op completes in one cycle
    logic             w_seq_load;   // sequencer delivers its result this cycle
    logic [WIDTH-1:0] w_seq_res;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;

    assign w_out_free = !r_out_valid | out_ready;
    assign w_fire_in  = in_valid & in_ready;

    // ------------------------------------------------------------------------
    // Single-cycle datapath. Unlisted opcodes (E, F, and A-D when the
    // sequencer is absent) fall through to ADD.
    // ------------------------------------------------------------------------
    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        case (op)
            c_op_sub: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            c_op_and:  begin w_alu_res = a & b;    w_alu_ovf = 1'b0; end
            c_op_or:   begin w_alu_res = a | b;    w_alu_ovf = 1'b0; end
            c_op_nor:  begin w_alu_res = ~(a | b); w_alu_ovf = 1'b0; end
            c_op_slt: begin
                w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                w_alu_ovf = 1'b0;
            end
            c_op_sltu: begin
                w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
                w_alu_ovf = 1'b0;
            end
            c_op_sll:  begin w_alu_res = b << shamt;            w_alu_ovf = 1'b0; end
            c_op_srl:  begin w_alu_res = b >> shamt;            w_alu_ovf = 1'b0; end
            c_op_sra:  begin w_alu_res = $signed(b) >>> shamt;  w_alu_ovf = 1'b0; end
            default: ;
        endcase
    end

`ifdef ALU_PIPE_MULDIV_EN
    // ------------------------------------------------------------------------
    // Iterative multiply/divide sequencer. One shared hi/lo register pair:
    //   MUL: {hi,lo} is the shift-add accumulator, lo starts as the multiplier.
    //   DIV: hi is the partial remainder, lo shifts the dividend out and the
    //        quotient bits in.
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_op_mullo = 4'hA;
    localparam logic [3:0] c_op_mulhu = 4'hB;
    localparam logic [3:0] c_op_divu  = 4'hC;
    localparam logic [3:0] c_op_remu  = 4'hD;
    localparam int         c_cnt_w    = SHW + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_sel_hi;

    logic               w_is_seq_op;
    logic               w_is_mul_op;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic               w_step;       // a shift step remains to be done
    logic               w_finish;     // last step done (or doing it) and output free

    assign w_is_seq_op = (op >= c_op_mullo) && (op <= c_op_remu);
    assign w_is_mul_op = (op == c_op_mullo) || (op == c_op_mulhu);

    assign w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});

    assign w_step      = (r_cnt != c_cnt_full);
    assign w_finish    = (r_cnt >= c_cnt_last) && w_out_free;

    assign in_ready    = (r_state == S_IDLE) & w_out_free;
    assign busy        = (r_state == S_MUL) | (r_state == S_DIV);
    assign w_single    = w_fire_in & !w_is_seq_op;
    assign w_seq_load  = (r_state == S_DONE);
    assign w_seq_res   = r_sel_hi ? r_hi : r_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_sel_hi <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fire_in && w_is_seq_op) begin
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        r_sel_hi <= (op == c_op_mulhu) || (op == c_op_remu);
                        if (w_is_mul_op) begin
                            r_lo    <= b;
                            r_opnd  <= a;
                            r_state <= S_MUL;
                        end else begin
                            r_lo    <= a;
                            r_opnd  <= b;
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (w_step) begin
                        r_hi  <= w_mul_sum[WIDTH:1];
                        r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                    if (w_finish) begin
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (w_step) begin
                        r_hi  <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        r_lo  <= {r_lo[WIDTH-2:0], w_div_ge};
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                    if (w_finish) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
`else
    assign in_ready   = w_out_free;
    assign busy       = 1'b0;
    assign w_single   = w_fire_in;
    assign w_seq_load = 1'b0;
    assign w_seq_res  = '0;
`endif

    // ------------------------------------------------------------------------
    // Output register. A new single-cycle result may replace one being
    // consumed in the same cycle; otherwise the contents are held until read.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
        end else if (w_single) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == '0);
            r_ovf       <= w_alu_ovf;
        end else if (w_seq_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_seq_res;
            r_zero      <= (w_seq_res == '0);
            r_ovf       <= 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Scoreboard bench for alu_pipe. The driver pushes the expected
//            {result, zero, overflow} when an op is accepted; a monitor pops
//            and compares whenever the DUT hands out a result, and checks
//            that a stalled output stays stable with in_ready low.
//            Multiply/divide vectors run when ALU_PIPE_MULDIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   op        = 4'h0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [4:0]   shamt     = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W+1:0] exp_q[$];

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: consumes results and checks stall behaviour.
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_out;
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h with no pending op", result);
            end else begin
                e = exp_q.pop_front();
                chk("out_result",   result,   e[W+1:2]);
                chk("out_zero",     zero,     e[1]);
                chk("out_overflow", overflow, e[0]);
            end
        end
        if (rst_n && out_valid && !out_ready) begin
            if (prev_stall)
                chk("hold_stable", {result, zero, overflow}, prev_out);
            chk("stall_in_ready", in_ready, 1'b0);
            prev_stall = 1'b1;
            prev_out   = {result, zero, overflow};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Present one op until accepted; on return we are 1 time unit after the
    // accepting clock edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [4:0] sh, input logic [W-1:0] er, input logic ez,
                         input logic eo, input bit push);
        bit ok;
        int guard;
        ok    = 1'b0;
        guard = 0;
        op = o; a = xa; b = xb; shamt = sh; in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            if (ok && push) exp_q.push_back({er, ez, eo});
            @(posedge clk); #1;
            guard++;
        end while (!ok && guard < 200);
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: op 0x%0h not accepted in %0d cycles", o, guard);
        end
        in_valid = 1'b0;
    endtask

`ifdef ALU_PIPE_MULDIV_EN
    task automatic measure_latency(input string name);
        int cyc;
        int bcnt;
        cyc  = 0;
        bcnt = 0;
        while (!out_valid && cyc < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, cyc, W + 1);
        chk({name, "_busy_cycles"}, bcnt, W);
    endtask
`endif

    initial begin
        int guard;
        bit seen;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result",    result,    '0);
        chk("rst_zero",      zero,      1'b1);
        chk("rst_overflow",  overflow,  1'b0);
        chk("rst_busy",      busy,      1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  in_ready,  1'b1);
        @(posedge clk); #1;

        // Single-cycle ops
        issue(4'h0, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        chk("add_latency", out_valid, 1'b1);
        issue(4'h1, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
        issue(4'h5, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1'b1);
        issue(4'h6, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
        issue(4'h9, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
        issue(4'h8, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b1);
        issue(4'h7, 32'h0, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        issue(4'h2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0, 1'b0, 1'b1);
        issue(4'h3, 32'hF000_0000, 32'h0000_000F, 5'd0, 32'hF000_000F, 1'b0, 1'b0, 1'b1);
        issue(4'h4, 32'hF000_0000, 32'h0000_000F, 5'd0, 32'h0FFF_FFF0, 1'b0, 1'b0, 1'b1);
        issue(4'h1, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        issue(4'h0, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
        issue(4'hE, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1'b1);
        issue(4'hF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);

        // Back-to-back stream: each accept must find the previous result out.
        for (int i = 0; i < 8; i++) begin
            issue(4'h0, W'(i), W'(i * 16), 5'd0, W'(i * 17), (i == 0), 1'b0, 1'b1);
            chk("stream_b2b_valid", out_valid, 1'b1);
        end

        // Stream with a 3-cycle consumer stall before the 4th op.
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                op = 4'h0; a = W'(32'h100 + i); b = W'(i); in_valid = 1'b1;
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                chk("stall_held_result", result, 32'h102 + 32'h2);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
            issue(4'h0, W'(32'h100 + i), W'(i), 5'd0, W'(32'h100 + 2 * i), 1'b0, 1'b0, 1'b1);
        end

`ifdef ALU_PIPE_MULDIV_EN
        issue(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        measure_latency("mulhu");
        issue(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        measure_latency("mullo");
        issue(4'hA, 32'd12345, 32'd0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
        issue(4'hC, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 1'b0, 1'b1);
        measure_latency("divu");
        issue(4'hD, 32'd100, 32'd7, 5'd0, 32'd2, 1'b0, 1'b0, 1'b1);
        issue(4'hC, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        measure_latency("divu_by0");
        issue(4'hD, 32'd9, 32'd0, 5'd0, 32'd9, 1'b0, 1'b0, 1'b1);
        issue(4'h1, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

        // Abort a divide with reset: nothing must come out.
        issue(4'hC, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_div_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",      busy,      1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        chk("abort_no_output", seen, 1'b0);
        issue(4'h0, 32'd40, 32'd2, 5'd0, 32'd42, 1'b0, 1'b0, 1'b1);
`else
        // Without the sequencer, ops A-D are single-cycle ADDs.
        issue(4'hA, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b0, 1'b1);
        chk("opA_latency", out_valid, 1'b1);
        chk("opA_busy", busy, 1'b0);
        issue(4'hD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        issue(4'hC, 32'd9, 32'd0, 5'd0, 32'd9, 1'b0, 1'b0, 1'b1);
`endif

        // Drain the scoreboard.
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's single-cycle MIPS ALU core.
- Accepts one operation per cycle over a valid/ready input handshake and returns a registered result with zero/overflow flags over a valid/ready output handshake.
- Iterative multiply/divide sequencer is compiled in optionally.
- Sits between decode/operand-fetch and writeback in the multi-cycle MIPS datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of 2)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  block accepts operation this cycle
op  input  4  operation select
a  input  WIDTH  operand A
b  input  WIDTH  operand B
shamt  input  SHW  shift amount for shift ops
out_valid  output  1  result register holds unconsumed result
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  registered: result == 0
overflow  output  1  registered signed overflow (ADD/SUB only)
busy  output  1  multi-cycle sequencer active

Behaviour:
- Reset (rst_n low, async): out_valid=0, result=0, zero=1, overflow=0, busy=0, state=IDLE, internal counters and accumulators cleared. in_ready reads 1 once reset is released.
- Accept: fire_in = in_valid & in_ready. Fire_out = out_valid & out_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready). This gives full throughput for single-cycle ops under continuous out_ready.
- Op encoding:
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND
  - 3 OR
  - 4 NOR
  - 5 SLT: signed compare, result is 1 or 0
  - 6 SLTU: unsigned compare
  - 7 SLL: b<<shamt
  - 8 SRL: b>>shamt, logical
  - 9 SRA: b>>>shamt, arithmetic
  - A MULLO, B MULHU, C DIVU, D REMU (multi-cycle; require the optional feature)
  - E, F illegal: behave as ADD
- Single-cycle ops: latency 1. The result, zero and overflow registers load on the clock edge of fire_in, and out_valid=1 on the next cycle.
- Output register holds result, zero and overflow stable while out_valid & !out_ready.
- Simultaneous fire_out and fire_in: the new result replaces the old one with no bubble.
- Fire_out without fire_in: out_valid goes to 0 next cycle.
- overflow: ADD is set when sign(a)==sign(b) and sign(sum)!=sign(a). SUB is set when sign(a)!=sign(b) and sign(diff)!=sign(a). It is 0 for all other ops. Carry-out is discarded.
- zero is computed from the value being loaded into result, so it is always consistent with result.
- Sequencer state machine:
  - IDLE -> MUL on fire_in with op A or B.
  - IDLE -> DIV on fire_in with op C or D.
  - MUL and DIV each run exactly WIDTH cycles, with busy=1 and in_ready=0 throughout.
  - MUL/DIV -> DONE when the count reaches WIDTH-1.
  - DONE: loads the result register, sets out_valid and returns to IDLE. DONE is only entered when the output register is free (!out_valid | out_ready); otherwise the block waits in MUL/DIV with the count saturated.
  - Total latency from accept to out_valid: WIDTH+1 cycles.
- MUL: unsigned shift-add on 2*WIDTH product. MULLO returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH].
- DIV: unsigned restoring division. DIVU returns quotient; REMU returns remainder.
- Divide by zero: quotient = all ones, remainder = a. The op still takes the full WIDTH cycles, and overflow=0.
- Operands are latched at accept. Input changes during busy are ignored.
- Reset mid-sequence aborts the operation, produces no output and returns to IDLE.

Optional Feature:
- Macro ALU_PIPE_MULDIV_EN.
- Defined: sequencer, product/quotient registers and ops A-D are implemented as above.
- Undefined:
  - No sequencer logic is built, and busy is tied to 0.
  - Ops A-D behave as ADD with single-cycle latency.
  - in_ready = !out_valid | out_ready.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, zero=0, out_valid one cycle after accept.
- SUB a=5 b=5 -> result 0, zero=1. Then SLT a=0xFFFFFFFF b=1 -> 1, and SLTU with the same operands -> 0.
- SRA b=0x80000000 shamt=4 -> 0xF8000000. SRL with the same inputs -> 0x08000000.
- Back-to-back stream of 8 ADDs with out_ready=1 -> 8 results on consecutive cycles. Repeat with out_ready held low 3 cycles mid-stream -> in_ready=0 and result held stable, with no loss or duplication.
- MULDIV_EN defined:
  - MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles, busy=1 for 32 cycles.
  - MULLO with the same operands -> 0x00000001.
- MULDIV_EN defined:
  - DIVU a=100 b=7 -> 14, and REMU -> 2.
  - DIVU a=9 b=0 -> 0xFFFFFFFF, and REMU -> 9.
  - rst_n pulsed low mid-DIV -> out_valid stays 0 and busy=0 immediately.
